// File: rtl/regfile_scoreboard_pkg.sv
// Shared register IDs, scoreboard defaults and the per-ID match helper.
package regfile_scoreboard_pkg;

    localparam int unsigned REG_ID_W  = 4;
    localparam int unsigned NREGS_DEF = 15;
    localparam int unsigned CNT_W_DEF = 2;

    // Architectural register IDs, shared with the register file
    localparam logic [REG_ID_W-1:0] RRAX  = 4'h0;
    localparam logic [REG_ID_W-1:0] RRCX  = 4'h1;
    localparam logic [REG_ID_W-1:0] RRDX  = 4'h2;
    localparam logic [REG_ID_W-1:0] RRBX  = 4'h3;
    localparam logic [REG_ID_W-1:0] RRSP  = 4'h4;
    localparam logic [REG_ID_W-1:0] RRBP  = 4'h5;
    localparam logic [REG_ID_W-1:0] RRSI  = 4'h6;
    localparam logic [REG_ID_W-1:0] RRDI  = 4'h7;
    localparam logic [REG_ID_W-1:0] R8    = 4'h8;
    localparam logic [REG_ID_W-1:0] R9    = 4'h9;
    localparam logic [REG_ID_W-1:0] R10   = 4'hA;
    localparam logic [REG_ID_W-1:0] R11   = 4'hB;
    localparam logic [REG_ID_W-1:0] R12   = 4'hC;
    localparam logic [REG_ID_W-1:0] R13   = 4'hD;
    localparam logic [REG_ID_W-1:0] R14   = 4'hE;
    localparam logic [REG_ID_W-1:0] RNONE = 4'hF;

    // Number of the two IDs (E and M port) that name register r: 0, 1 or 2
    function automatic logic [1:0] id_match(input logic [REG_ID_W-1:0] id_a,
                                            input logic [REG_ID_W-1:0] id_b,
                                            input logic [REG_ID_W-1:0] r);
        logic [1:0] m_a;
        logic [1:0] m_b;
        m_a = 2'((id_a == r) && (r != RNONE));
        m_b = 2'((id_b == r) && (r != RNONE));
        return m_a + m_b;
    endfunction

endpackage

// File: rtl/regfile_scoreboard_counter.sv
// One per-register pending-write counter: +inc on issue, -dec on retire,
// clamps at zero on an over-retire and reports it as a one-cycle pulse.
module sb_counter #(
    parameter int unsigned CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clear,
    input  logic [1:0]       i_inc,
    input  logic [1:0]       i_dec,
    output logic [CNT_W-1:0] o_cnt,
    output logic [CNT_W-1:0] o_cnt_nxt_c,
    output logic             o_full_c,
    output logic             o_underflow_c
);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W:0]   w_cnt_ext;
    logic [CNT_W:0]   w_inc_ext;
    logic [CNT_W:0]   w_dec_ext;

    assign w_cnt_ext = (CNT_W+1)'(r_cnt);
    assign w_inc_ext = (CNT_W+1)'(i_inc);
    assign w_dec_ext = (CNT_W+1)'(i_dec);

    // Next count; the underflow test is against the current count, so an
    // over-retire drops the stale pending writes but keeps a same-cycle issue
    always_comb begin
        o_cnt_nxt_c   = r_cnt;
        o_underflow_c = 1'b0;
        if (i_clear) begin
            o_cnt_nxt_c = '0;
        end else if (w_dec_ext > w_cnt_ext) begin
            o_underflow_c = 1'b1;
            o_cnt_nxt_c   = CNT_W'(w_inc_ext);
        end else begin
            o_cnt_nxt_c = CNT_W'(w_cnt_ext - w_dec_ext + w_inc_ext);
        end
    end

    // Counter state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_cnt <= '0;
        else        r_cnt <= o_cnt_nxt_c;
    end

    assign o_cnt    = r_cnt;
    assign o_full_c = (r_cnt == {CNT_W{1'b1}});

endmodule

// File: rtl/regfile_scoreboard.sv
// Register-file scoreboard: counts writes in flight between decode and
// writeback and stalls decode on read-after-write or counter saturation.
// Optional macro REGFILE_SCOREBOARD_BYPASS_EN: a source whose pending count
// is fully retired this cycle is not a hazard (forward path supplies it).
module regfile_scoreboard
    import regfile_scoreboard_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF,
    parameter int unsigned NREGS = NREGS_DEF
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               flush,
    input  logic               id_valid,
    input  logic [3:0]         id_srcA,
    input  logic [3:0]         id_srcB,
    input  logic [3:0]         id_dstE,
    input  logic [3:0]         id_dstM,
    output logic               id_stall,
    input  logic [3:0]         wb_dstE,
    input  logic [3:0]         wb_dstM,
    output logic [NREGS-1:0]   busy,
    output logic [CNT_W+3:0]   outstanding,
    output logic               err_underflow
);

    localparam int unsigned  SUM_W   = CNT_W + 4;
    localparam logic [CNT_W:0] CNT_MAX = (CNT_W+1)'((1 << CNT_W) - 1);

    logic [CNT_W-1:0] w_cnt     [NREGS];
    logic [CNT_W-1:0] w_cnt_nxt [NREGS];
    logic [1:0]       w_inc_raw [NREGS];
    logic [1:0]       w_inc     [NREGS];
    logic [1:0]       w_dec     [NREGS];
    logic [NREGS-1:0] w_full;
    logic [NREGS-1:0] w_uflow;
    logic [NREGS-1:0] w_src_hit;
    logic [NREGS-1:0] w_src_blk;
    logic [NREGS-1:0] w_over;
    logic             w_hazard;
    logic             w_issue;
    logic [SUM_W-1:0] w_sum_nxt;
    logic [SUM_W-1:0] r_outstanding;
    logic             r_err;

    genvar g;
    generate
        for (g = 0; g < NREGS; g++) begin : g_reg
            assign w_inc_raw[g] = id_match(id_dstE, id_dstM, REG_ID_W'(g));
            assign w_dec[g]     = id_match(wb_dstE, wb_dstM, REG_ID_W'(g));
            assign w_inc[g]     = w_issue ? w_inc_raw[g] : 2'd0;
            assign w_src_hit[g] = (id_srcA == REG_ID_W'(g)) || (id_srcB == REG_ID_W'(g));
`ifdef REGFILE_SCOREBOARD_BYPASS_EN
            assign w_src_blk[g] = ((CNT_W+1)'(w_cnt[g]) != (CNT_W+1)'(w_dec[g]));
`else
            assign w_src_blk[g] = (w_cnt[g] != '0);
`endif
            assign w_over[g]    = w_full[g] ? (w_inc_raw[g] != 2'd0)
                                : (((CNT_W+1)'(w_cnt[g]) + (CNT_W+1)'(w_inc_raw[g])) > CNT_MAX);
            assign busy[g]      = (w_cnt[g] != '0);

            sb_counter #(.CNT_W(CNT_W)) u_cnt (
                .clk           (clock),
                .rst_n         (reset_n),
                .i_clear       (flush),
                .i_inc         (w_inc[g]),
                .i_dec         (w_dec[g]),
                .o_cnt         (w_cnt[g]),
                .o_cnt_nxt_c   (w_cnt_nxt[g]),
                .o_full_c      (w_full[g]),
                .o_underflow_c (w_uflow[g])
            );
        end
    endgenerate

    assign w_hazard = (|(w_src_hit & w_src_blk)) | (|w_over);
    assign id_stall = id_valid & w_hazard;
    assign w_issue  = id_valid & ~w_hazard & ~flush;

    // Total of the next counter values, registered alongside the counters
    always_comb begin
        w_sum_nxt = '0;
        for (int r = 0; r < NREGS; r++) begin
            w_sum_nxt = w_sum_nxt + SUM_W'(w_cnt_nxt[r]);
        end
    end

    // Outstanding total and sticky underflow flag (flush does not clear it)
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_outstanding <= '0;
            r_err         <= 1'b0;
        end else begin
            r_outstanding <= w_sum_nxt;
            r_err         <= r_err | (|w_uflow);
        end
    end

    assign outstanding   = r_outstanding;
    assign err_underflow = r_err;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Randomized + directed bench for regfile_scoreboard against a counting model.
module tb_regfile_scoreboard;

    localparam int NR  = 15;
    localparam int MAX = 3;
    localparam int NO  = 15;

    logic        clock = 1'b0;
    logic        reset_n = 1'b1;
    logic        flush = 1'b0;
    logic        id_valid = 1'b0;
    logic [3:0]  id_srcA = 4'hF;
    logic [3:0]  id_srcB = 4'hF;
    logic [3:0]  id_dstE = 4'hF;
    logic [3:0]  id_dstM = 4'hF;
    logic        id_stall;
    logic [3:0]  wb_dstE = 4'hF;
    logic [3:0]  wb_dstM = 4'hF;
    logic [14:0] busy;
    logic [5:0]  outstanding;
    logic        err_underflow;

    int n_checks = 0;
    int n_errors = 0;
    int m_cnt [NR];
    bit m_err;

    regfile_scoreboard dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .flush         (flush),
        .id_valid      (id_valid),
        .id_srcA       (id_srcA),
        .id_srcB       (id_srcB),
        .id_dstE       (id_dstE),
        .id_dstM       (id_dstM),
        .id_stall      (id_stall),
        .wb_dstE       (wb_dstE),
        .wb_dstM       (wb_dstM),
        .busy          (busy),
        .outstanding   (outstanding),
        .err_underflow (err_underflow)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int nmatch(input int a, input int b, input int r);
        return ((a == r) ? 1 : 0) + ((b == r) ? 1 : 0);
    endfunction

    // A source read must wait while writes to it are still pending
    function automatic bit src_haz(input int id, input int wa, input int wb);
        if (id >= NR) return 1'b0;
`ifdef REGFILE_SCOREBOARD_BYPASS_EN
        return m_cnt[id] != nmatch(wa, wb, id);
`else
        return m_cnt[id] != 0;
`endif
    endfunction

    function automatic bit exp_stall(input bit v, input int sa, input int sb,
                                     input int de, input int dm, input int wa, input int wb);
        if (!v) return 1'b0;
        if (src_haz(sa, wa, wb) || src_haz(sb, wa, wb)) return 1'b1;
        if (de < NR && m_cnt[de] + nmatch(de, dm, de) > MAX) return 1'b1;
        if (dm < NR && m_cnt[dm] + nmatch(de, dm, dm) > MAX) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] exp_busy();
        logic [31:0] b = '0;
        for (int r = 0; r < NR; r++) if (m_cnt[r] != 0) b[r] = 1'b1;
        return b;
    endfunction

    function automatic logic [31:0] exp_out();
        int s = 0;
        for (int r = 0; r < NR; r++) s += m_cnt[r];
        return 32'(s);
    endfunction

    task automatic idle_inputs();
        id_valid = 1'b0; flush = 1'b0;
        id_srcA = 4'hF; id_srcB = 4'hF; id_dstE = 4'hF; id_dstM = 4'hF;
        wb_dstE = 4'hF; wb_dstM = 4'hF;
    endtask

    task automatic check_regs(input string tag);
        check({tag, ":busy"}, 32'(busy), exp_busy());
        check({tag, ":outstanding"}, 32'(outstanding), exp_out());
        check({tag, ":err"}, 32'(err_underflow), 32'(m_err));
    endtask

    // Called at posedge+1; returns at the following posedge+1
    task automatic do_reset(input string tag);
        idle_inputs();
        reset_n = 1'b0;
        for (int r = 0; r < NR; r++) m_cnt[r] = 0;
        m_err = 1'b0;
        #2;
        check_regs(tag);
        check({tag, ":stall"}, 32'(id_stall), 32'd0);
        @(posedge clock);
        #1 reset_n = 1'b1;
    endtask

    // One clock of stimulus: check the combinational stall, then the state
    task automatic cycle(input bit v, input int sa, input int sb, input int de, input int dm,
                         input int wa, input int wb, input bit fl, input string tag);
        bit st;
        bit issue;
        int inc;
        int dec;
        id_valid = v; flush = fl;
        id_srcA = 4'(sa); id_srcB = 4'(sb); id_dstE = 4'(de); id_dstM = 4'(dm);
        wb_dstE = 4'(wa); wb_dstM = 4'(wb);
        st = exp_stall(v, sa, sb, de, dm, wa, wb);
        #3;
        check({tag, ":stall"}, 32'(id_stall), 32'(st));
        @(posedge clock);
        issue = v && !st && !fl;
        for (int r = 0; r < NR; r++) begin
            if (fl) begin
                m_cnt[r] = 0;
            end else begin
                inc = issue ? nmatch(de, dm, r) : 0;
                dec = nmatch(wa, wb, r);
                if (dec > m_cnt[r]) begin
                    m_err    = 1'b1;
                    m_cnt[r] = inc;
                end else begin
                    m_cnt[r] = m_cnt[r] - dec + inc;
                end
            end
        end
        #1;
        check_regs(tag);
    endtask

    function automatic int pick_id();
        int x = int'($urandom_range(0, 9));
        return (x >= 6) ? NO : x;
    endfunction

    initial begin
        #1;
        do_reset("reset");

        // Read-after-write on rax, retired through the E port
        cycle(1, NO, NO, 0,  NO, NO, NO, 0, "iss_rax");
        cycle(1, 0,  NO, NO, NO, NO, NO, 0, "raw_rax");
        check("raw_rax:busy0", 32'(busy[0]), 32'd1);
        check("raw_rax:out1", 32'(outstanding), 32'd1);
        cycle(1, 0,  NO, NO, NO, 0,  NO, 0, "wb_rax");
        cycle(1, 0,  NO, NO, NO, NO, NO, 0, "raw_clear");

        // popq-style double destination on rsp
        cycle(1, NO, NO, 4,  4,  NO, NO, 0, "popq");
        check("popq:out2", 32'(outstanding), 32'd2);
        cycle(0, NO, NO, NO, NO, NO, 4,  0, "wbM_rsp");
        cycle(0, NO, NO, NO, NO, 4,  NO, 0, "wbE_rsp");
        check("wbE_rsp:noerr", 32'(err_underflow), 32'd0);

        // Saturation on rcx: fourth issue must stall
        for (int i = 0; i < 4; i++) cycle(1, NO, NO, 1, NO, NO, NO, 0, "sat_rcx");
        check("sat_rcx:out3", 32'(outstanding), 32'd3);
        cycle(1, NO, NO, 1,  1,  1,  NO, 0, "sat_double");

        // Underflow on an idle register; sticky across flush
        cycle(0, NO, NO, NO, NO, 2,  NO, 0, "uflow");
        check("uflow:err1", 32'(err_underflow), 32'd1);
        cycle(1, NO, NO, 6,  NO, NO, NO, 1, "flush_keep_err");
        do_reset("reset_clr_err");

        // Flush drops all pending writes and the same-cycle issue
        cycle(1, NO, NO, 0,  NO, NO, NO, 0, "load_rax");
        cycle(1, NO, NO, 3,  3,  NO, NO, 0, "load_rbx");
        cycle(1, NO, NO, 5,  NO, 0,  NO, 1, "flush");
        check("flush:out0", 32'(outstanding), 32'd0);

        // Same-cycle issue and retire on one register
        cycle(1, NO, NO, 7,  NO, NO, NO, 0, "pre_rdi");
        cycle(1, NO, NO, 7,  NO, 7,  NO, 0, "issue_retire_rdi");

        // Reset mid-cycle clears outputs without a clock edge
        cycle(1, NO, NO, 0,  NO, NO, NO, 0, "mid_load");
        id_valid = 1'b1; id_srcA = 4'h0;
        #2 reset_n = 1'b0;
        #1;
        check("midrst:busy", 32'(busy), 32'd0);
        check("midrst:outstanding", 32'(outstanding), 32'd0);
        check("midrst:stall", 32'(id_stall), 32'd0);
        @(posedge clock);
        #1;
        do_reset("midrst_done");

        // Randomized traffic with periodic resets
        for (int n = 0; n < 1500; n++) begin
            if (n % 250 == 249) begin
                do_reset("rnd_reset");
            end else begin
                cycle(bit'($urandom_range(0, 3) != 0), pick_id(), pick_id(), pick_id(), pick_id(),
                      ($urandom_range(0, 2) == 0) ? pick_id() : NO,
                      ($urandom_range(0, 3) == 0) ? pick_id() : NO,
                      bit'($urandom_range(0, 29) == 0), "rnd");
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
